// File: rtl/divmod_unit_if.sv
// divmod_unit_if: start/done handshake and operand/result bus of the
// iterative divider.
//   master : execute-stage side. Drives start_i, a_i and b_i. Observes busy_o,
//            done_o, quotient_o, remainder_o and div_by_zero_o.
//   slave  : divider side. The directions are the reverse of the master side.
// Signal names carry the divider's _i/_o suffixes, so both sides see the
// same names the divider documents.
interface divmod_unit_if #(
  parameter int unsigned N = 4
);
  logic         start_i;
  logic [N-1:0] a_i;
  logic [N-1:0] b_i;
  logic         busy_o;
  logic         done_o;
  logic [N-1:0] quotient_o;
  logic [N-1:0] remainder_o;
  logic         div_by_zero_o;

  modport master (
    output start_i, a_i, b_i,
    input  busy_o, done_o, quotient_o, remainder_o, div_by_zero_o
  );

  modport slave (
    input  start_i, a_i, b_i,
    output busy_o, done_o, quotient_o, remainder_o, div_by_zero_o
  );
endinterface

// File: rtl/divmod_unit.sv
// divmod_unit: iterative unsigned restoring divider. It produces one quotient
// bit per clock and gives the execute stage quotient and remainder for
// modular reduction.
//   clk_i  : clock. All state changes on the rising edge.
//   rst_i  : synchronous, active-high reset. It clears all state.
//   bus    : divmod_unit_if slave.
//            start_i, a_i, b_i        : request and operands. They are sampled
//                                       only when the unit can accept.
//            busy_o                   : high while steps are running.
//            done_o                   : one-cycle pulse with a valid result.
//            quotient_o, remainder_o  : result. It holds until the next accept.
//            div_by_zero_o            : the latched divisor was zero.
// Every output comes from a register. No input has a combinational path to
// any output.
module divmod_unit #(
  parameter int unsigned N = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  divmod_unit_if.slave bus
);

  localparam int unsigned CW = (N < 2) ? 1 : $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e        state_q;
  logic [N:0]    r_q;
  logic [N-1:0]  q_q;
  logic [N-1:0]  d_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic          done_q;
  logic          dbz_q;

  // One restoring step. T is {R,Q} shifted left by one. Bit N of T - {0,D}
  // is the borrow, and it decides whether the subtraction is kept.
  logic [N:0]    t_d;
  logic [N:0]    diff_d;
  logic [N-1:0]  q_shift_d;
  logic          take_d;

  always_comb begin
    t_d       = '0;
    diff_d    = '0;
    q_shift_d = '0;
    take_d    = 1'b0;
    t_d       = {r_q[N-1:0], q_q[N-1]};
    diff_d    = t_d - {1'b0, d_q};
    take_d    = ~diff_d[N];
    q_shift_d = {q_q[N-1:0], 1'b0} | {{(N-1){1'b0}}, take_d};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          r_q   <= take_d ? diff_d : t_d;
          q_q   <= q_shift_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(N - 1)) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          // IDLE and DONE both accept. The DONE pulse lasts one cycle, and a
          // start in that cycle begins the next operation without a bubble.
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          if (bus.start_i) begin
            if (bus.b_i != '0) begin
              r_q     <= '0;
              q_q     <= bus.a_i;
              d_q     <= bus.b_i;
              cnt_q   <= '0;
              dbz_q   <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= S_RUN;
            end else begin
              r_q     <= {1'b0, bus.a_i};
              q_q     <= '1;
              d_q     <= '0;
              cnt_q   <= '0;
              dbz_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
      endcase
    end
  end

  assign bus.busy_o        = busy_q;
  assign bus.done_o        = done_q;
  assign bus.quotient_o    = q_q;
  assign bus.remainder_o   = r_q[N-1:0];
  assign bus.div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_divmod_unit.sv
module tb_divmod_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  divmod_unit_if #(.N(4)) bus4 ();
  divmod_unit_if #(.N(8)) bus8 ();

  divmod_unit #(.N(4)) dut4 (.clk_i(clk), .rst_i(rst), .bus(bus4));
  divmod_unit #(.N(8)) dut8 (.clk_i(clk), .rst_i(rst), .bus(bus8));

  int checks = 0;
  int errors = 0;
  int lat;
  int busy_cnt;
  int dpulses;
  logic [7:0] ra, rb, eq, er;
  logic       ed;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Starts one N=4 operation, scrambles the operands after the accept edge,
  // then waits a bounded number of cycles for done_o.
  task automatic op4(input string tag, input logic [3:0] a, input logic [3:0] b,
                     input int eq4, input int er4, input int ed4, input int elat);
    int l;
    int bc;
    bus4.a_i = a; bus4.b_i = b; bus4.start_i = 1'b1;
    tick();
    bus4.start_i = 1'b0; bus4.a_i = ~a; bus4.b_i = 4'd1;
    l = 1; bc = 0;
    if (bus4.busy_o) bc++;
    while (!bus4.done_o && l < 20) begin
      tick(); l++;
      if (bus4.busy_o) bc++;
    end
    chk({tag, " latency"}, l, elat);
    chk({tag, " busy cycles"}, bc, (ed4 != 0) ? 0 : 4);
    chk({tag, " quotient"}, bus4.quotient_o, eq4);
    chk({tag, " remainder"}, bus4.remainder_o, er4);
    chk({tag, " dbz"}, bus4.div_by_zero_o, ed4);
  endtask

  initial begin
    bus4.start_i = 1'b0; bus4.a_i = '0; bus4.b_i = '0;
    bus8.start_i = 1'b0; bus8.a_i = '0; bus8.b_i = '0;
    rst = 1'b1;
    tick(); tick();
    chk("reset busy", bus4.busy_o, 0);
    chk("reset done", bus4.done_o, 0);
    chk("reset quotient", bus4.quotient_o, 0);
    chk("reset remainder", bus4.remainder_o, 0);
    chk("reset dbz", bus4.div_by_zero_o, 0);
    rst = 1'b0;
    tick();

    op4("13/3", 4'd13, 4'd3, 4, 1, 0, 5);
    tick();
    chk("13/3 done single", bus4.done_o, 0);
    chk("13/3 hold q", bus4.quotient_o, 4);
    chk("13/3 hold r", bus4.remainder_o, 1);

    op4("7/0", 4'd7, 4'd0, 15, 7, 1, 1);
    tick();
    chk("7/0 done single", bus4.done_o, 0);
    op4("15/1", 4'd15, 4'd1, 15, 0, 0, 5);
    op4("2/9", 4'd2, 4'd9, 0, 2, 0, 5);
    op4("15/15", 4'd15, 4'd15, 1, 0, 0, 5);

    // A start during RUN is ignored. The second 6/2 request comes in the DONE
    // cycle and is accepted there.
    tick();
    bus4.a_i = 4'd13; bus4.b_i = 4'd3; bus4.start_i = 1'b1;
    tick();
    bus4.start_i = 1'b0;
    tick();
    bus4.a_i = 4'd6; bus4.b_i = 4'd2; bus4.start_i = 1'b1;
    tick();
    bus4.start_i = 1'b0;
    lat = 0;
    while (!bus4.done_o && lat < 20) begin tick(); lat++; end
    chk("ignore start q", bus4.quotient_o, 4);
    chk("ignore start r", bus4.remainder_o, 1);
    chk("ignore start wait", lat, 2);
    op4("b2b 6/2", 4'd6, 4'd2, 3, 0, 0, 5);

    // Reset on the second RUN step edge. A start on that same edge is ignored.
    tick();
    bus4.a_i = 4'd13; bus4.b_i = 4'd3; bus4.start_i = 1'b1;
    tick();
    bus4.start_i = 1'b0;
    tick();
    rst = 1'b1; bus4.start_i = 1'b1;
    tick();
    rst = 1'b0; bus4.start_i = 1'b0;
    chk("abort busy", bus4.busy_o, 0);
    chk("abort done", bus4.done_o, 0);
    chk("abort quotient", bus4.quotient_o, 0);
    chk("abort remainder", bus4.remainder_o, 0);
    chk("abort dbz", bus4.div_by_zero_o, 0);
    dpulses = 0; busy_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus4.done_o) dpulses++;
      if (bus4.busy_o) busy_cnt++;
    end
    chk("abort no done", dpulses, 0);
    chk("abort idle", busy_cnt, 0);
    op4("9/4", 4'd9, 4'd4, 2, 1, 0, 5);

    // N=8 sweep. It includes forced b=0, b=1 and a<b cases.
    for (int i = 0; i < 1000; i++) begin
      if (i % 10 == 0) begin
        ra = 8'($urandom_range(0, 255)); rb = 8'd0;
      end else if (i % 10 == 1) begin
        ra = 8'($urandom_range(0, 255)); rb = 8'd1;
      end else if (i % 10 == 2) begin
        rb = 8'($urandom_range(1, 255));
        ra = 8'($urandom_range(0, int'(rb) - 1));
      end else begin
        ra = 8'($urandom_range(0, 255)); rb = 8'($urandom_range(0, 255));
      end
      if (rb == 8'd0) begin
        eq = 8'hFF; er = ra; ed = 1'b1;
      end else begin
        eq = ra / rb; er = ra % rb; ed = 1'b0;
      end
      bus8.a_i = ra; bus8.b_i = rb; bus8.start_i = 1'b1;
      tick();
      bus8.start_i = 1'b0; bus8.a_i = $urandom_range(0, 255); bus8.b_i = 8'd7;
      lat = 1;
      while (!bus8.done_o && lat < 30) begin tick(); lat++; end
      chk("n8 latency", lat, ed ? 1 : 9);
      chk("n8 quotient", bus8.quotient_o, eq);
      chk("n8 remainder", bus8.remainder_o, er);
      chk("n8 dbz", bus8.div_by_zero_o, ed);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
